ifid_hazard_ctrl: RTL and testbench
===================================

// Module: ifid_hazard_ctrl
// PURPOSE
//  Sequences the IF/ID pipeline register and the PC: stalls on load-use hazards, inserts NOPs on
//  instruction-memory wait, flushes on taken branches. Sits beside IF/ID, drives its enable/flush,
//  the PC enable and the ID/EX bubble select. Keeps saturating stall/flush perf counters.
// PARAMETERS
//  LU_STALL_CYC  1   total stall cycles per load-use hazard (1 = with forwarding, 2 = without); range 1..7
//  CNT_W         16  width of stall_cnt / flush_cnt
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      asynchronous, active-high reset
//  id_rs1        in   5      rs1 field of instruction in IF/ID
//  id_rs2        in   5      rs2 field of instruction in IF/ID
//  id_uses_rs1   in   1      ID instruction reads rs1
//  id_uses_rs2   in   1      ID instruction reads rs2
//  ex_mem_read   in   1      instruction in EX is a load
//  ex_rd         in   5      destination register of EX instruction
//  branch_taken  in   1      EX resolved a taken branch/jump this cycle
//  imem_ready    in   1      instruction memory returns valid data this cycle
//  pc_en         out  1      PC may update
//  ifid_en       out  1      IF/ID captures its input
//  ifid_flush    out  1      IF/ID loads NOP 32'h00000013 (overrides ifid_en)
//  idex_bubble   out  1      ID/EX loads a bubble instead of decoded ID
//  state_o       out  2      FSM state: 0 RUN, 1 LU_STALL, 2 IMISS
//  stall_cnt     out  CNT_W  cycles with pc_en=0 (saturating)
//  flush_cnt     out  CNT_W  branch flushes taken (saturating)
// BEHAVIOUR
//  - clk is the only clock. rst is asynchronous, active-high: state=RUN, lu_cnt=0, counters=0.
//  - While rst=1: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1.
//  - Outputs are combinational from the current state and inputs (0-cycle latency). State and
//    counters update on posedge clk.
//  - hazard = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
//  - Priority in every state: branch_taken > hazard (RUN only) > !imem_ready.
//  - Branch (any state): pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1. Next=RUN, lu_cnt=0.
//    This aborts a pending load-use stall or I-miss. flush_cnt+1.
//  - RUN + hazard: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1.
//    If LU_STALL_CYC>1: next=LU_STALL, lu_cnt=LU_STALL_CYC-1. Else next=RUN.
//  - RUN + !imem_ready: pc_en=0, ifid_en=1, ifid_flush=1, idex_bubble=0. Next=IMISS.
//  - RUN otherwise: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
//  - LU_STALL (no branch): outputs as RUN+hazard; hazard is not re-evaluated.
//    lu_cnt decrements; when lu_cnt==1 at the edge, next=RUN.
//  - IMISS (no branch): if imem_ready, outputs as RUN-normal and next=RUN. Else outputs as
//    RUN+!imem_ready and the FSM stays in IMISS.
//  - Unused state encoding 3 returns to RUN on the next edge; outputs equal RUN-normal.
//  - stall_cnt +1 on each cycle with pc_en=0 and rst=0. Both counters stick at 2^CNT_W-1.
// TESTING
//  1 Reset mid-stall: assert rst in LU_STALL -> same cycle state_o=0, pc_en=0, ifid_flush=1.
//    After release, counters=0.
//  2 Load-use, LU_STALL_CYC=2: ex_mem_read=1, ex_rd=5, id_uses_rs1=1, id_rs1=5
//    -> pc_en=0, ifid_en=0, idex_bubble=1 for exactly 2 cycles, then RUN; stall_cnt=2.
//  3 No false hazard: ex_rd=0, id_rs1=0, loads active -> pc_en stays 1.
//    Also ex_rd=5, id_uses_rs2=0, id_rs2=5 -> no stall.
//  4 I-miss: imem_ready=0 for 3 cycles -> state_o=2, ifid_flush=1, pc_en=0 for 3 cycles.
//    imem_ready=1 -> pc_en=1, ifid_flush=0 that cycle.
//  5 Branch vs hazard: branch_taken=1 with hazard true in RUN, then branch in LU_STALL
//    -> flush wins both times: ifid_flush=1, idex_bubble=1, pc_en=1, next state RUN;
//    flush_cnt=2.
//  6 Saturation, CNT_W=4: hold imem_ready=0 for 20 cycles -> stall_cnt=15 and stays 15.

Source files
------------

// File: rtl/ifid_hazard_if.sv
// Pipeline-side signals seen by the IF/ID hazard controller.
// master = pipeline (drives ID/EX/IMEM status), slave = controller (drives enables).
interface ifid_hazard_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       branch_taken;
  logic       imem_ready;
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_bubble;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           branch_taken, imem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_bubble
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           branch_taken, imem_ready,
    output pc_en, ifid_en, ifid_flush, idex_bubble
  );
endinterface

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID + PC sequencer: load-use stalls, I-miss NOP insertion, branch flush,
// with saturating stall/flush counters.
module ifid_hazard_ctrl #(
  parameter int LU_STALL_CYC = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  ifid_hazard_if.slave     bus,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    IMISS    = 2'd2,
    UNUSED   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             hazard;
  logic             pc_en_c, ifid_en_c, flush_c, bubble_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign hazard = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                  ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                   (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      lu_cnt_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    if (bus.branch_taken) begin
      state_d  = RUN;
      lu_cnt_d = 3'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            if (LU_STALL_CYC > 1) begin
              state_d  = LU_STALL;
              lu_cnt_d = 3'(LU_STALL_CYC - 1);
            end
          end else if (!bus.imem_ready) begin
            state_d = IMISS;
          end
        end
        LU_STALL: begin
          lu_cnt_d = lu_cnt_q - 3'd1;
          if (lu_cnt_q <= 3'd1) begin
            state_d  = RUN;
            lu_cnt_d = 3'd0;
          end
        end
        IMISS:   if (bus.imem_ready) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Reset forces a frozen PC with a NOP in IF/ID and a bubble into ID/EX.
  always_comb begin
    pc_en_c   = 1'b1;
    ifid_en_c = 1'b1;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;
    if (rst) begin
      pc_en_c   = 1'b0;
      ifid_en_c = 1'b0;
      flush_c   = 1'b1;
      bubble_c  = 1'b1;
    end else if (bus.branch_taken) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            pc_en_c   = 1'b0;
            ifid_en_c = 1'b0;
            bubble_c  = 1'b1;
          end else if (!bus.imem_ready) begin
            pc_en_c = 1'b0;
            flush_c = 1'b1;
          end
        end
        LU_STALL: begin
          pc_en_c   = 1'b0;
          ifid_en_c = 1'b0;
          bubble_c  = 1'b1;
        end
        IMISS: begin
          if (!bus.imem_ready) begin
            pc_en_c = 1'b0;
            flush_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en_c)         stall_cnt_q <= sat_inc(stall_cnt_q);
      if (bus.branch_taken) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign bus.pc_en       = pc_en_c;
  assign bus.ifid_en     = ifid_en_c;
  assign bus.ifid_flush  = flush_c;
  assign bus.idex_bubble = bubble_c;
  assign state_o         = state_q;
  assign stall_cnt       = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Bench for ifid_hazard_ctrl: two instances (LU_STALL_CYC=2/CNT_W=4 and
// LU_STALL_CYC=1/CNT_W=16) driven by identical stimulus against a stall/miss model.
module tb_ifid_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       u1 = 0, u2 = 0, mr = 0, br = 0, rdy = 1;

  ifid_hazard_if ifa ();
  ifid_hazard_if ifb ();

  assign {ifa.id_rs1, ifa.id_rs2, ifa.id_uses_rs1, ifa.id_uses_rs2, ifa.ex_mem_read,
          ifa.ex_rd, ifa.branch_taken, ifa.imem_ready} = {rs1, rs2, u1, u2, mr, rd, br, rdy};
  assign {ifb.id_rs1, ifb.id_rs2, ifb.id_uses_rs1, ifb.id_uses_rs2, ifb.ex_mem_read,
          ifb.ex_rd, ifb.branch_taken, ifb.imem_ready} = {rs1, rs2, u1, u2, mr, rd, br, rdy};

  logic [1:0]  st_a, st_b;
  logic [3:0]  sc_a, fc_a;
  logic [15:0] sc_b, fc_b;

  ifid_hazard_ctrl #(.LU_STALL_CYC(2), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .state_o(st_a), .stall_cnt(sc_a), .flush_cnt(fc_a));
  ifid_hazard_ctrl #(.LU_STALL_CYC(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .state_o(st_b), .stall_cnt(sc_b), .flush_cnt(fc_b));

  int checks = 0;
  int errors = 0;

  // Model: remaining stall cycles, pending I-miss flag, and plain counters.
  int lu_k[2]  = '{2, 1};
  int max_k[2] = '{15, 65535};
  int m_left[2];
  bit m_miss[2];
  int m_scnt[2];
  int m_fcnt[2];

  function automatic bit hz();
    return mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
  endfunction

  // {pc_en, ifid_en, ifid_flush, idex_bubble}
  function automatic logic [3:0] exp_out(int k);
    if (rst) return 4'b0011;
    if (br) return 4'b1111;
    if (m_left[k] > 0) return 4'b0001;
    if (m_miss[k]) return rdy ? 4'b1100 : 4'b0110;
    if (hz()) return 4'b0001;
    if (!rdy) return 4'b0110;
    return 4'b1100;
  endfunction

  function automatic int exp_state(int k);
    if (rst) return 0;
    if (m_left[k] > 0) return 1;
    if (m_miss[k]) return 2;
    return 0;
  endfunction

  function automatic logic [3:0] obs_out(int k);
    if (k == 0) return {ifa.pc_en, ifa.ifid_en, ifa.ifid_flush, ifa.idex_bubble};
    return {ifb.pc_en, ifb.ifid_en, ifb.ifid_flush, ifb.idex_bubble};
  endfunction

  function automatic int obs_state(int k);
    return (k == 0) ? int'(st_a) : int'(st_b);
  endfunction

  function automatic int obs_scnt(int k);
    return (k == 0) ? int'(sc_a) : int'(sc_b);
  endfunction

  function automatic int obs_fcnt(int k);
    return (k == 0) ? int'(fc_a) : int'(fc_b);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_miss[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
    end
  endtask

  task automatic tick();
    logic [3:0] o;
    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        o = exp_out(k);
        if (br) begin
          m_left[k] = 0; m_miss[k] = 0;
          if (m_fcnt[k] < max_k[k]) m_fcnt[k]++;
        end else if (m_left[k] > 0) m_left[k]--;
        else if (m_miss[k]) begin
          if (rdy) m_miss[k] = 0;
        end else if (hz()) m_left[k] = lu_k[k] - 1;
        else if (!rdy) m_miss[k] = 1;
        if (!o[3] && m_scnt[k] < max_k[k]) m_scnt[k]++;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mr = 0; br = 0; rdy = 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; #2;
    rst = 0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst = 1;
    #1;
    checks++;
    if (obs_out(0) !== 4'b0011) begin errors++; $display("FAIL reset_out_a got %b want 0011", obs_out(0)); end
    checks++;
    if (obs_out(1) !== 4'b0011) begin errors++; $display("FAIL reset_out_b got %b want 0011", obs_out(1)); end
    checks++;
    if (st_a !== 2'd0 || sc_a !== 4'd0 || fc_a !== 4'd0) begin
      errors++; $display("FAIL reset_regs_a got st=%0d sc=%0d fc=%0d want 0", st_a, sc_a, fc_a);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    rs1 = 5; u1 = 1; mr = 1; rd = 5; #1;
    checks++;
    if (obs_out(0) !== 4'b0001 || obs_out(1) !== 4'b0001) begin
      errors++; $display("FAIL lu_cycle0 got a=%b b=%b want 0001", obs_out(0), obs_out(1));
    end
    tick();
    mr = 0; #1;
    checks++;
    if (obs_out(0) !== 4'b0001 || st_a !== 2'd1) begin
      errors++; $display("FAIL lu_cycle1_a got out=%b st=%0d want 0001 st=1", obs_out(0), st_a);
    end
    checks++;
    if (obs_out(1) !== 4'b1100 || st_b !== 2'd0) begin
      errors++; $display("FAIL lu_cycle1_b got out=%b st=%0d want 1100 st=0", obs_out(1), st_b);
    end
    tick(); #1;
    checks++;
    if (obs_out(0) !== 4'b1100 || st_a !== 2'd0) begin
      errors++; $display("FAIL lu_done_a got out=%b st=%0d want 1100 st=0", obs_out(0), st_a);
    end
    checks++;
    if (sc_a !== 4'd2 || sc_b !== 16'd1) begin
      errors++; $display("FAIL lu_stall_cnt got a=%0d b=%0d want a=2 b=1", sc_a, sc_b);
    end
    idle_inputs();
  endtask

  task automatic test_no_false_hazard();
    do_reset();
    mr = 1; rd = 0; rs1 = 0; u1 = 1; #1;
    checks++;
    if (ifa.pc_en !== 1'b1 || ifb.pc_en !== 1'b1) begin
      errors++; $display("FAIL nfh_x0 got pc_en a=%b b=%b want 1", ifa.pc_en, ifb.pc_en);
    end
    tick();
    rd = 5; u1 = 0; rs1 = 5; u2 = 0; rs2 = 5; #1;
    checks++;
    if (ifa.pc_en !== 1'b1 || ifb.pc_en !== 1'b1) begin
      errors++; $display("FAIL nfh_unused got pc_en a=%b b=%b want 1", ifa.pc_en, ifb.pc_en);
    end
    tick();
    checks++;
    if (sc_a !== 4'd0 || sc_b !== 16'd0) begin
      errors++; $display("FAIL nfh_cnt got a=%0d b=%0d want 0", sc_a, sc_b);
    end
    idle_inputs();
  endtask

  task automatic test_imiss();
    do_reset();
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs_out(0) !== 4'b0110 || obs_out(1) !== 4'b0110) begin
        errors++; $display("FAIL imiss_c%0d got a=%b b=%b want 0110", i, obs_out(0), obs_out(1));
      end
      if (i > 0) begin
        checks++;
        if (st_a !== 2'd2 || st_b !== 2'd2) begin
          errors++; $display("FAIL imiss_st%0d got a=%0d b=%0d want 2", i, st_a, st_b);
        end
      end
      tick();
    end
    rdy = 1; #1;
    checks++;
    if (obs_out(0) !== 4'b1100 || st_a !== 2'd2) begin
      errors++; $display("FAIL imiss_ready got out=%b st=%0d want 1100 st=2", obs_out(0), st_a);
    end
    tick();
    checks++;
    if (st_a !== 2'd0 || sc_a !== 4'd3 || sc_b !== 16'd3) begin
      errors++; $display("FAIL imiss_end got st=%0d sc_a=%0d sc_b=%0d want 0 3 3", st_a, sc_a, sc_b);
    end
  endtask

  task automatic test_branch_vs_hazard();
    do_reset();
    mr = 1; rd = 5; rs1 = 5; u1 = 1; br = 1; #1;
    checks++;
    if (obs_out(0) !== 4'b1111 || obs_out(1) !== 4'b1111) begin
      errors++; $display("FAIL br_run got a=%b b=%b want 1111", obs_out(0), obs_out(1));
    end
    tick();
    br = 0; #1;
    checks++;
    if (st_a !== 2'd0 || fc_a !== 4'd1 || obs_out(0) !== 4'b0001) begin
      errors++; $display("FAIL br_after got st=%0d fc=%0d out=%b want 0 1 0001", st_a, fc_a, obs_out(0));
    end
    tick();
    br = 1; mr = 0; #1;
    checks++;
    if (st_a !== 2'd1 || obs_out(0) !== 4'b1111) begin
      errors++; $display("FAIL br_lustall got st=%0d out=%b want 1 1111", st_a, obs_out(0));
    end
    tick();
    br = 0; #1;
    checks++;
    if (st_a !== 2'd0 || fc_a !== 4'd2 || fc_b !== 16'd2) begin
      errors++; $display("FAIL br_cnt got st=%0d fc_a=%0d fc_b=%0d want 0 2 2", st_a, fc_a, fc_b);
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    rdy = 0;
    repeat (20) tick();
    checks++;
    if (sc_a !== 4'd15 || sc_b !== 16'd20) begin
      errors++; $display("FAIL sat_20 got a=%0d b=%0d want 15 20", sc_a, sc_b);
    end
    repeat (3) tick();
    checks++;
    if (sc_a !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", sc_a); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    mr = 1; rd = 5; rs1 = 5; u1 = 1; #1;
    tick();
    mr = 0; #1;
    checks++;
    if (st_a !== 2'd1) begin errors++; $display("FAIL rms_pre got st=%0d want 1", st_a); end
    rst = 1; #1;
    checks++;
    if (st_a !== 2'd0 || obs_out(0) !== 4'b0011) begin
      errors++; $display("FAIL rms_same got st=%0d out=%b want 0 0011", st_a, obs_out(0));
    end
    tick();
    rst = 0;
    model_reset();
    #1;
    checks++;
    if (sc_a !== 4'd0 || fc_a !== 4'd0 || sc_b !== 16'd0 || st_a !== 2'd0) begin
      errors++; $display("FAIL rms_after got sc_a=%0d fc_a=%0d sc_b=%0d st=%0d want 0", sc_a, fc_a, sc_b, st_a);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      mr  = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_out(k) !== exp_out(k) || obs_state(k) != exp_state(k)) begin
          errors++;
          $display("FAIL rand_out i%0d n%0d got out=%b st=%0d want out=%b st=%0d",
                   k, n, obs_out(k), obs_state(k), exp_out(k), exp_state(k));
        end
        checks++;
        if (obs_scnt(k) != m_scnt[k] || obs_fcnt(k) != m_fcnt[k]) begin
          errors++;
          $display("FAIL rand_cnt i%0d n%0d got sc=%0d fc=%0d want sc=%0d fc=%0d",
                   k, n, obs_scnt(k), obs_fcnt(k), m_scnt[k], m_fcnt[k]);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_imiss();
    test_branch_vs_hazard();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
